hdmi_src_sched: RTL and testbench

HDMI_SRC_SCHED -- requirements
Module: hdmi_src_sched

---
 rtl/hdmi_src_sched_pkg.sv | 30 +++
 rtl/hdmi_vs_edge.sv | 20 ++
 rtl/hdmi_src_sched.sv | 125 ++++++++++++
 tb/tb_hdmi_src_sched.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_src_sched_pkg.sv
// Shared constants, state encoding and request decode for the HDMI source scheduler.
package hdmi_src_sched_pkg;

  localparam int RGB_W = 24;

  localparam logic [1:0] SRC_SIGGEN = 2'd0;
  localparam logic [1:0] SRC_OSC_T  = 2'd1;
  localparam logic [1:0] SRC_OSC_F  = 2'd2;
  localparam logic [1:0] SRC_LA     = 2'd3;

  typedef enum logic [1:0] {
    RUN,
    WAIT_VS,
    BLANK
  } state_t;

  // Menu position to source code; anything not mapped falls back to the signal generator.
  function automatic logic [1:0] decode_req(input logic       level,
                                            input logic [1:0] cnt_level1,
                                            input logic       fft_confirm);
    logic [1:0] sel;
    sel = SRC_SIGGEN;
    if (level) begin
      if (cnt_level1 == 2'd1) sel = fft_confirm ? SRC_OSC_F : SRC_OSC_T;
      else if (cnt_level1 == 2'd2) sel = SRC_LA;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hdmi_vs_edge.sv
// Frame-start detector: one-cycle pulse when vsync enters its active level.
module hdmi_vs_edge #(
  parameter logic VS_POL = 1'b1
) (
  input  logic pclk,
  input  logic rst,
  input  logic vs,
  output logic fs
);

  logic vs_d_reg;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) vs_d_reg <= ~VS_POL;
    else     vs_d_reg <= vs;
  end

  assign fs = (vs == VS_POL) && (vs_d_reg != VS_POL);

endmodule

// File: rtl/hdmi_src_sched.sv
// Selects one of four video sources, switching only on a frame start of the
// displayed source and optionally blacking out whole frames afterwards.
module hdmi_src_sched
  import hdmi_src_sched_pkg::*;
#(
  parameter int unsigned BLANK_FRAMES = 1,
  parameter logic        VS_POL       = 1'b1
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             level,
  input  logic [1:0]       cnt_level1,
  input  logic             fft_confirm,
  input  logic [3:0]       src_vs,
  input  logic [3:0]       src_hs,
  input  logic [3:0]       src_de,
  input  logic [4*RGB_W-1:0] src_rgb,
  output logic             vs_out,
  output logic             hs_out,
  output logic             de_out,
  output logic [RGB_W-1:0] rgb_out,
  output logic [1:0]       sel_out,
  output logic             busy,
  output logic [15:0]      frame_cnt
);

  localparam logic [3:0] BLANK_INIT = 4'(BLANK_FRAMES);

  state_t           state_reg, state_next;
  logic [1:0]       cur_sel_reg, cur_sel_next;
  logic [1:0]       pend_reg, pend_next;
  logic [3:0]       blank_cnt_reg, blank_cnt_next;
  logic [15:0]      frame_cnt_reg, frame_cnt_next;
  logic [1:0]       req_sel;
  logic             fs;
  logic             commit;
  logic [RGB_W-1:0] rgb_src [4];
  logic [RGB_W-1:0] rgb_next;

  for (genvar gi = 0; gi < 4; gi++) begin : g_rgb_split
    assign rgb_src[gi] = src_rgb[gi*RGB_W +: RGB_W];
  end

  assign req_sel = decode_req(level, cnt_level1, fft_confirm);

  hdmi_vs_edge #(.VS_POL(VS_POL)) u_vs_edge (
    .pclk (pclk),
    .rst  (rst),
    .vs   (src_vs[cur_sel_reg]),
    .fs   (fs)
  );

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_reg     <= RUN;
      cur_sel_reg   <= SRC_SIGGEN;
      pend_reg      <= SRC_SIGGEN;
      blank_cnt_reg <= 4'd0;
      frame_cnt_reg <= 16'd0;
    end else begin
      state_reg     <= state_next;
      cur_sel_reg   <= cur_sel_next;
      pend_reg      <= pend_next;
      blank_cnt_reg <= blank_cnt_next;
      frame_cnt_reg <= frame_cnt_next;
    end
  end

  // A cancel (request back to the displayed source) beats a coincident frame start.
  always_comb begin
    state_next     = state_reg;
    cur_sel_next   = cur_sel_reg;
    pend_next      = pend_reg;
    blank_cnt_next = blank_cnt_reg;
    commit         = 1'b0;
    frame_cnt_next = fs ? frame_cnt_reg + 16'd1 : frame_cnt_reg;
    case (state_reg)
      RUN: begin
        if (req_sel != cur_sel_reg) begin
          pend_next  = req_sel;
          state_next = WAIT_VS;
        end
      end
      WAIT_VS: begin
        pend_next = req_sel;
        if (req_sel == cur_sel_reg) begin
          state_next = RUN;
        end else if (fs) begin
          commit         = 1'b1;
          cur_sel_next   = pend_reg;
          blank_cnt_next = BLANK_INIT;
          state_next     = (BLANK_INIT == 4'd0) ? RUN : BLANK;
        end
      end
      BLANK: begin
        if (fs) begin
          blank_cnt_next = blank_cnt_reg - 4'd1;
          if (blank_cnt_reg == 4'd1) state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  assign rgb_next = (state_reg == BLANK || commit) ? '0 : rgb_src[cur_sel_reg];

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vs_out  <= 1'b0;
      hs_out  <= 1'b0;
      de_out  <= 1'b0;
      rgb_out <= '0;
    end else begin
      vs_out  <= src_vs[cur_sel_reg];
      hs_out  <= src_hs[cur_sel_reg];
      de_out  <= src_de[cur_sel_reg];
      rgb_out <= rgb_next;
    end
  end

  assign sel_out   = cur_sel_reg;
  assign busy      = (state_reg != RUN);
  assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_hdmi_src_sched.sv
// Bench for hdmi_src_sched: two instances (1 and 0 blank frames) checked every cycle against a frame-level model.
module tb_hdmi_src_sched;

  logic        pclk = 1'b0;
  logic        rst = 1'b0;
  logic        level, fft_confirm;
  logic [1:0]  cnt_level1;
  logic [3:0]  src_vs, src_hs, src_de;
  logic [95:0] src_rgb;

  logic [1:0]        vs_o, hs_o, de_o, busy_o;
  logic [1:0][23:0]  rgb_o;
  logic [1:0][1:0]   sel_o;
  logic [1:0][15:0]  fc_o;

  int compared = 0;
  int mismatched = 0;

  always #5 pclk = ~pclk;

  hdmi_src_sched #(.BLANK_FRAMES(1), .VS_POL(1'b1)) dut (
    .pclk(pclk), .rst(rst), .level(level), .cnt_level1(cnt_level1), .fft_confirm(fft_confirm),
    .src_vs(src_vs), .src_hs(src_hs), .src_de(src_de), .src_rgb(src_rgb),
    .vs_out(vs_o[0]), .hs_out(hs_o[0]), .de_out(de_o[0]), .rgb_out(rgb_o[0]),
    .sel_out(sel_o[0]), .busy(busy_o[0]), .frame_cnt(fc_o[0]));

  hdmi_src_sched #(.BLANK_FRAMES(0), .VS_POL(1'b1)) dut0 (
    .pclk(pclk), .rst(rst), .level(level), .cnt_level1(cnt_level1), .fft_confirm(fft_confirm),
    .src_vs(src_vs), .src_hs(src_hs), .src_de(src_de), .src_rgb(src_rgb),
    .vs_out(vs_o[1]), .hs_out(hs_o[1]), .de_out(de_o[1]), .rgb_out(rgb_o[1]),
    .sel_out(sel_o[1]), .busy(busy_o[1]), .frame_cnt(fc_o[1]));

  // ---------------- behavioural model ----------------
  int               m_mode [2];   // 0 showing, 1 waiting for frame start, 2 black frames
  int               m_sel  [2];
  int               m_pend [2];
  int               m_left [2];
  logic [15:0]      m_cnt  [2];
  bit               m_prev [2];
  logic [1:0]       e_vs, e_hs, e_de;
  logic [1:0][23:0] e_rgb;
  bit               preload_req = 1'b0;
  logic [15:0]      preload_val = 16'd0;
  int               t_req, t_old;
  bit               t_hit, t_fs, t_sw;

  function automatic int want_src(input logic lv, input logic [1:0] c, input logic f);
    if (!lv) return 0;
    if (c == 2'd1) return f ? 2 : 1;
    if (c == 2'd2) return 3;
    return 0;
  endfunction

  function automatic int blank_frames(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

  always @(posedge pclk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_mode[k] = 0; m_sel[k] = 0; m_pend[k] = 0; m_left[k] = 0;
        m_cnt[k] = 16'd0; m_prev[k] = 1'b0;
      end
      e_vs = '0; e_hs = '0; e_de = '0; e_rgb = '0;
    end else begin
      t_req = want_src(level, cnt_level1, fft_confirm);
      for (int k = 0; k < 2; k++) begin
        t_hit = (src_vs[m_sel[k]] == 1'b1);
        t_fs = t_hit && !m_prev[k];
        m_prev[k] = t_hit;
        if (preload_req) m_cnt[k] = preload_val;
        if (t_fs) m_cnt[k] = m_cnt[k] + 16'd1;
        t_sw = (m_mode[k] == 1) && (t_req != m_sel[k]) && t_fs;
        e_vs[k] = src_vs[m_sel[k]];
        e_hs[k] = src_hs[m_sel[k]];
        e_de[k] = src_de[m_sel[k]];
        e_rgb[k] = (m_mode[k] == 2 || t_sw) ? 24'h0 : src_rgb[24*m_sel[k] +: 24];
        t_old = m_pend[k];
        if (m_mode[k] == 0) begin
          if (t_req != m_sel[k]) begin m_pend[k] = t_req; m_mode[k] = 1; end
        end else if (m_mode[k] == 1) begin
          m_pend[k] = t_req;
          if (t_req == m_sel[k]) m_mode[k] = 0;
          else if (t_fs) begin
            m_sel[k] = t_old;
            m_left[k] = blank_frames(k);
            m_mode[k] = (m_left[k] == 0) ? 0 : 2;
          end
        end else if (t_fs) begin
          m_left[k] = m_left[k] - 1;
          if (m_left[k] == 0) m_mode[k] = 0;
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("vs_out[%0d]", k),  32'(vs_o[k]),  32'(e_vs[k]));
      chk($sformatf("hs_out[%0d]", k),  32'(hs_o[k]),  32'(e_hs[k]));
      chk($sformatf("de_out[%0d]", k),  32'(de_o[k]),  32'(e_de[k]));
      chk($sformatf("rgb_out[%0d]", k), 32'(rgb_o[k]), 32'(e_rgb[k]));
      chk($sformatf("sel_out[%0d]", k), 32'(sel_o[k]), 32'(m_sel[k]));
      chk($sformatf("busy[%0d]", k),    32'(busy_o[k]), 32'(m_mode[k] != 0));
      chk($sformatf("frame_cnt[%0d]", k), 32'(fc_o[k]), 32'(m_cnt[k]));
    end
  endtask

  task automatic cyc(input logic [3:0] vs);
    @(negedge pclk);
    compare_all();
    preload_req = 1'b0;
    src_vs = vs;
    src_hs = 4'($urandom);
    src_de = 4'($urandom);
  endtask

  task automatic pulse();
    cyc(4'hF);
    repeat (3) cyc(4'h0);
  endtask

  initial begin
    level = 1'b1; cnt_level1 = 2'd2; fft_confirm = 1'b0;
    src_vs = '0; src_hs = '0; src_de = '0;
    src_rgb = {24'h445566, 24'h332211, 24'hABCDEF, 24'h123456};
    #2 rst = 1'b1;
    repeat (3) cyc(4'h0);
    chk("reset_sel", 32'(sel_o[0]), 32'd0);
    chk("reset_busy", 32'(busy_o[0]), 32'd0);
    chk("reset_rgb", 32'(rgb_o[0]), 32'd0);
    rst = 1'b0;

    // reset test: request LA, wait for first frame start of source 0
    repeat (3) cyc(4'h0);
    chk("pre_fs_sel", 32'(sel_o[0]), 32'd0);
    chk("pre_fs_busy", 32'(busy_o[0]), 32'd1);
    pulse();
    chk("rt_sel", 32'(sel_o[0]), 32'd3);
    chk("rt_busy_blank", 32'(busy_o[0]), 32'd1);
    chk("rt_rgb_blank", 32'(rgb_o[0]), 32'd0);
    chk("rt_bf0_rgb", 32'(rgb_o[1]), 32'h445566);
    pulse();
    chk("rt_rgb_la", 32'(rgb_o[0]), 32'h445566);
    chk("rt_busy_done", 32'(busy_o[0]), 32'd0);
    chk("rt_frames", 32'(fc_o[0]), 32'd2);

    // cancel test
    cnt_level1 = 2'd1;
    repeat (2) cyc(4'h0);
    chk("cancel_wait_busy", 32'(busy_o[0]), 32'd1);
    cnt_level1 = 2'd2;
    cyc(4'h0);
    chk("cancel_busy_drop", 32'(busy_o[0]), 32'd0);
    pulse();
    chk("cancel_sel", 32'(sel_o[0]), 32'd3);
    chk("cancel_rgb", 32'(rgb_o[0]), 32'h445566);

    // back to source 0, then retarget 1 -> 3 -> 2
    level = 1'b0;
    repeat (2) pulse();
    chk("home_sel", 32'(sel_o[0]), 32'd0);
    level = 1'b1; cnt_level1 = 2'd1; fft_confirm = 1'b0;
    repeat (2) cyc(4'h0);
    cnt_level1 = 2'd2;
    repeat (2) cyc(4'h0);
    cnt_level1 = 2'd1; fft_confirm = 1'b1;
    repeat (2) cyc(4'h0);
    pulse();
    chk("retarget_sel", 32'(sel_o[0]), 32'd2);
    chk("retarget_blank", 32'(busy_o[0]), 32'd1);
    pulse();
    chk("retarget_rgb", 32'(rgb_o[0]), 32'h332211);
    chk("retarget_busy", 32'(busy_o[0]), 32'd0);

    // cancel and frame start on the same cycle
    level = 1'b0;
    repeat (2) cyc(4'h0);
    cyc(4'hF);
    level = 1'b1;
    repeat (3) cyc(4'h0);
    chk("simul_sel", 32'(sel_o[0]), 32'd2);
    chk("simul_busy", 32'(busy_o[0]), 32'd0);
    chk("simul_frames", 32'(fc_o[0]), 32'd8);
    chk("simul_frames_bf0", 32'(fc_o[1]), 32'd8);

    // zero blank frames: 0 -> 1
    level = 1'b0;
    repeat (2) pulse();
    level = 1'b1; cnt_level1 = 2'd1; fft_confirm = 1'b0;
    repeat (2) cyc(4'h0);
    chk("bf0_before", 32'(rgb_o[1]), 32'h123456);
    chk("bf0_wait_busy", 32'(busy_o[1]), 32'd1);
    cyc(4'hF);
    cyc(4'h0);
    chk("bf0_zero", 32'(rgb_o[1]), 32'h0);
    chk("bf0_busy", 32'(busy_o[1]), 32'd0);
    chk("bf0_sel", 32'(sel_o[1]), 32'd1);
    cyc(4'h0);
    chk("bf0_after", 32'(rgb_o[1]), 32'hABCDEF);
    cyc(4'h0);
    pulse();

    // frame counter wrap, then reset in the middle of a blank frame
    cyc(4'h0);
    #2;
    force dut.frame_cnt_reg = 16'hFFFE;
    force dut0.frame_cnt_reg = 16'hFFFE;
    preload_val = 16'hFFFE;
    preload_req = 1'b1;
    @(negedge pclk);
    release dut.frame_cnt_reg;
    release dut0.frame_cnt_reg;
    level = 1'b0;
    repeat (2) cyc(4'h0);
    pulse();
    chk("wrap_ffff", 32'(fc_o[0]), 32'hFFFF);
    pulse();
    chk("wrap_zero", 32'(fc_o[0]), 32'h0);
    chk("wrap_zero_bf0", 32'(fc_o[1]), 32'h0);
    level = 1'b1; cnt_level1 = 2'd2;
    repeat (2) cyc(4'h0);
    pulse();
    chk("mid_blank_busy", 32'(busy_o[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rgb", 32'(rgb_o[0]), 32'h0);
    chk("async_vs_hs_de", 32'({vs_o[0], hs_o[0], de_o[0]}), 32'h0);
    chk("async_sel", 32'(sel_o[0]), 32'd0);
    chk("async_busy", 32'(busy_o[0]), 32'd0);
    chk("async_frames", 32'(fc_o[0]), 32'd0);
    repeat (2) cyc(4'h0);
    rst = 1'b0;
    repeat (3) cyc(4'h0);
    chk("post_rst_sel", 32'(sel_o[0]), 32'd0);
    chk("post_rst_busy", 32'(busy_o[0]), 32'd1);
    pulse();
    chk("post_rst_switch", 32'(sel_o[0]), 32'd3);
    repeat (2) pulse();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
